// File: rtl/ex_stage_exmem.sv
// Execute stage plus EX/MEM pipeline register.
//
// Takes the ID/EX register outputs. It forwards operands from its own EX/MEM
// register and from WB, decodes the ALU control and executes. It resolves
// branches and registers all results for MEM. An R-type MULT runs as an
// iterative shift-add over DATA_W cycles and stalls upstream while it runs.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   flush                 squash the EX/MEM entry and abort a running MULT
//   pc_plus4              PC+4 of the instruction in ID/EX
//   rs_val, rt_val        register operands
//   sign_ext              immediate (bits [5:0] carry funct)
//   rs_addr, rt_addr, rd_addr        register addresses
//   regDest .. RegWrite, ALUOp       ID/EX control signals
//   wb_RegWrite, wb_addr, wb_data    WB write port, used for forwarding
//   stall_out             hold PC, IF/ID and ID/EX this cycle
//   *_out (others)        registered EX/MEM fields
module ex_stage_exmem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              regDest,
    input  logic              branch,
    input  logic              MemRead,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic [1:0]        ALUOp,
    input  logic              wb_RegWrite,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [ADDR_W-1:0] write_addr_out,
    output logic              branch_taken_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic              MemRead_out,
    output logic              MemtoReg_out,
    output logic              MemWrite_out,
    output logic              RegWrite_out
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    // EX/MEM register
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic              branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0] branch_target_q, branch_target_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic              reg_write_q, reg_write_d;

    // Iterative multiplier state
    logic [DATA_W-1:0] mcand_q, mplier_q, prod_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [5:0]        funct;
    logic              funct_ok, is_mult;
    logic              stall, bubble, use_prod, mult_start;

    assign funct = sign_ext[5:0];

    // Forwarding: the younger EX/MEM result takes priority over WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rs_val;
        if (reg_write_q && (write_addr_q != '0) && (write_addr_q == rs_addr)) begin
            fwd_a = alu_result_q;
        end else if (wb_RegWrite && (wb_addr != '0) && (wb_addr == rs_addr)) begin
            fwd_a = wb_data;
        end
        fwd_b = rt_val;
        if (reg_write_q && (write_addr_q != '0) && (write_addr_q == rt_addr)) begin
            fwd_b = alu_result_q;
        end else if (wb_RegWrite && (wb_addr != '0) && (wb_addr == rt_addr)) begin
            fwd_b = wb_data;
        end
    end

    assign alu_b = ALUSrc ? sign_ext : fwd_b;

    always_comb begin
        alu_res  = '0;
        funct_ok = 1'b1;
        is_mult  = 1'b0;
        unique case (ALUOp)
            2'b00: alu_res = fwd_a + alu_b;
            2'b01: alu_res = fwd_a - alu_b;
            2'b11: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
            2'b10: begin
                case (funct)
                    FUNCT_ADD:  alu_res = fwd_a + alu_b;
                    FUNCT_SUB:  alu_res = fwd_a - alu_b;
                    FUNCT_AND:  alu_res = fwd_a & alu_b;
                    FUNCT_OR:   alu_res = fwd_a | alu_b;
                    FUNCT_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                           ($signed(fwd_a) < $signed(alu_b))};
                    FUNCT_MULT: is_mult = 1'b1;
                    default:    funct_ok = 1'b0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the MULT left in ID/EX during StDone is not restarted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (is_mult && !flush) state_d = StBusy;
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        stall    = 1'b0;
        bubble   = 1'b0;
        use_prod = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mult && !flush) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            StBusy: begin
                stall  = !flush;
                bubble = 1'b1;
            end
            StDone:  use_prod = 1'b1;
            default: stall = 1'b0;
        endcase
        if (flush) bubble = 1'b1;
    end

    assign stall_out  = stall & reset;
    assign mult_start = (state_q == StIdle) && (state_d == StBusy);

    // Shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (mult_start) begin
            mcand_q  <= fwd_a;
            mplier_q <= fwd_b;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (state_q == StBusy) begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // EX/MEM next values; a bubble clears only the controls.
    always_comb begin
        alu_result_d    = use_prod ? prod_q : alu_res;
        store_data_d    = fwd_b;
        write_addr_d    = regDest ? rd_addr : rt_addr;
        branch_target_d = pc_plus4 + (sign_ext << 2);
        branch_taken_d  = branch && (fwd_a == fwd_b) && !bubble;
        mem_read_d      = MemRead && !bubble;
        mem_to_reg_d    = MemtoReg && !bubble;
        mem_write_d     = MemWrite && !bubble;
        reg_write_d     = RegWrite && funct_ok && !bubble;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_result_q    <= '0;
            store_data_q    <= '0;
            write_addr_q    <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            mem_read_q      <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            write_addr_q    <= write_addr_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            mem_read_q      <= mem_read_d;
            mem_to_reg_q    <= mem_to_reg_d;
            mem_write_q     <= mem_write_d;
            reg_write_q     <= reg_write_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign write_addr_out    = write_addr_q;
    assign branch_taken_out  = branch_taken_q;
    assign branch_target_out = branch_target_q;
    assign MemRead_out       = mem_read_q;
    assign MemtoReg_out      = mem_to_reg_q;
    assign MemWrite_out      = mem_write_q;
    assign RegWrite_out      = reg_write_q;

endmodule
